data_mem_bridge: RTL and testbench
==================================

Name: data_mem_bridge

Overview:
Sits directly downstream of the CPU's data-memory port and services every load/store issued from its MEM stage. Decodes each word address to one of two targets: an internal data RAM, or a small memory-mapped I/O window. The I/O window holds a TX FIFO drained over a valid/ready stream, a status register, and a free-running cycle counter. Read data is combinational, so the CPU captures it into MEM/WB at the next edge with zero wait states.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, word-address width
DMEM_DEPTH, 1024, RAM words; power of two
TX_FIFO_DEPTH, 4, FIFO entries; power of two, >=2
MMIO_BASE, 32'hFFFF_FFF0, word address of the first MMIO register

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
data_mem_addr_i  in  ADDR_WIDTH  word address from the CPU MEM stage
data_mem_read_i  in  1  load strobe
data_mem_write_i  in  1  store strobe
data_mem_write_data_i  in  DATA_WIDTH  store data
data_mem_read_data_o  out  DATA_WIDTH  load data (combinational)
tx_data_o  out  DATA_WIDTH  FIFO head word
tx_valid_o  out  1  FIFO not empty
tx_ready_i  in  1  consumer accepts the head word

Behaviour:
- Reset: the following are cleared asynchronously.
  - FIFO pointers and count = 0
  - overflow and unmapped flags = 0
  - cycle counter = 0
  - tx_valid_o = 0, tx_data_o = 0
  - RAM contents are NOT reset.
  - Reset asserted mid-transfer discards all FIFO contents.
- Address map (word addresses):
  - RAM: addr < DMEM_DEPTH.
  - TXDATA at MMIO_BASE+0. Write pushes the word; read returns 0.
  - STATUS at MMIO_BASE+1. Read fields:
    - [7:0] FIFO count
    - [8] full
    - [9] empty
    - [10] overflow (sticky)
    - [11] unmapped (sticky)
    - other bits 0
    - Write: each 1 in bits 10/11 clears that flag; other bits are ignored.
  - CYCLE at MMIO_BASE+2. Read returns the counter. Write loads the counter.
  - Any other address is unmapped: read returns 0, write is dropped, and the unmapped flag is set on either access.
- Read path:
  - data_mem_read_data_o is driven combinationally from the address when data_mem_read_i=1; it is 0 when data_mem_read_i=0.
  - A read and a write to the same RAM address in the same cycle return the old value; the write lands at the edge.
- RAM write: word written at the rising edge when data_mem_write_i=1 and the address maps to RAM.
- TX FIFO (registered storage, no bypass):
  - Push = store to TXDATA.
  - Pop = tx_valid_o & tx_ready_i.
  - Latency: a push into an empty FIFO gives tx_valid_o=1 on the following cycle.
  - tx_data_o = head entry when non-empty, 0 when empty.
  - When full, a push is accepted only if a pop happens in the same cycle; count stays at DEPTH.
  - When full with no pop, the push is dropped, the overflow flag is set, and the contents are unchanged.
  - Simultaneous push and pop when non-full: count is unchanged.
  - Pointers wrap modulo TX_FIFO_DEPTH.
  - tx_data_o and tx_valid_o stay stable while tx_valid_o=1 and tx_ready_i=0.
- Cycle counter:
  - Increments by 1 every cycle and wraps from 2^32-1 to 0.
  - A write to CYCLE loads write_data at the edge; that cycle does not increment.
  - A read returns the pre-edge value.
- Flag precedence: a STATUS write that clears a flag and an event that sets the same flag in the same cycle resolve to set (the event wins).
- Read and write strobes both high: the write is performed and the read data is still driven.
- Address arithmetic compares the full ADDR_WIDTH; addresses are never truncated to RAM index bits.

Decomposition:
- Shared defines header (existing def.v style) holds:
  - MMIO register offsets (TXDATA=0, STATUS=1, CYCLE=2)
  - STATUS bit positions (FULL=8, EMPTY=9, OVF=10, UNMAP=11)
- One sub-module: mmio_tx_fifo (sync FIFO with push/pop/full/empty/count and async active-high reset).
- Address decode, RAM, counter and flags live in data_mem_bridge.

Test Plan:
- Store 0xDEADBEEF to addr 5, then load addr 5 next cycle → read_data=0xDEADBEEF. Same-cycle load of addr 5 during a store of 0x1 → returns the prior value.
- With tx_ready_i=0, push 0x11,0x22,0x33,0x44 to TXDATA:
  - STATUS count=4, full=1.
  - A fifth push of 0x55 is dropped and sets overflow.
  - Raise ready → tx_data_o sequence is 0x11,0x22,0x33,0x44; then tx_valid_o=0 and empty=1.
- FIFO full, tx_ready_i=1, push 0x99 in the same cycle → count stays 4, overflow stays 0, and 0x99 emerges last.
- Write 0xFFFFFFFE to CYCLE, read on successive cycles → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Load from 0x8000_0000 → 0 returned and STATUS[11]=1. Write STATUS 0x800 → flag clears. Clear issued in the same cycle as another unmapped access → flag stays 1.
- Assert rst_i asynchronously (mid-clock) with 3 FIFO entries pending → tx_valid_o=0 immediately, count=0, and RAM word 5 still holds 0xDEADBEEF.

Source files
------------

// File: rtl/data_mem_bridge_pkg.sv
// data_mem_bridge_pkg: MMIO register offsets and STATUS bit positions shared by the bridge
package data_mem_bridge_pkg;
    localparam int MMIO_TXDATA  = 0;
    localparam int MMIO_STATUS  = 1;
    localparam int MMIO_CYCLE   = 2;
    localparam int STATUS_FULL  = 8;
    localparam int STATUS_EMPTY = 9;
    localparam int STATUS_OVF   = 10;
    localparam int STATUS_UNMAP = 11;
endpackage

// File: rtl/data_mem_bridge_mmio_tx_fifo.sv
// mmio_tx_fifo: registered TX FIFO behind the TXDATA register, drained over valid/ready
module mmio_tx_fifo
    import data_mem_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [7:0]            o_count,
    output logic                  o_drop
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [PW:0]           r_count;
    logic                  w_pop;
    logic                  w_acc;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (PW+1)'(DEPTH);
    assign o_valid = ~o_empty;
    assign o_count = 8'(r_count);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign w_pop   = o_valid & i_ready;
    // a push into a full FIFO only fits when the head leaves in the same cycle
    assign w_acc   = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & o_full & ~w_pop;
    // pointers and occupancy; reset discards every pending entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_acc ? r_wr + PW'(1) : r_wr;
            r_rd    <= w_pop ? r_rd + PW'(1) : r_rd;
            r_count <= (w_acc & ~w_pop) ? r_count + (PW+1)'(1) :
                       (~w_acc & w_pop) ? r_count - (PW+1)'(1) : r_count;
        end
    end
    // entry storage is not reset; only occupancy decides what is visible
    always_ff @(posedge clk_i) begin
        if (w_acc) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: decodes CPU data accesses to RAM or the TX/STATUS/CYCLE MMIO window
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  ADDR_WIDTH    = 32,
    parameter int                  DMEM_DEPTH    = 1024,
    parameter int                  TX_FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] data_mem_addr_i,
    input  logic                  data_mem_read_i,
    input  logic                  data_mem_write_i,
    input  logic [DATA_WIDTH-1:0] data_mem_write_data_i,
    output logic [DATA_WIDTH-1:0] data_mem_read_data_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i
);
    localparam int RAW = $clog2(DMEM_DEPTH);
    logic [DATA_WIDTH-1:0] r_ram [DMEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_cycle;
    logic                  r_ovf;
    logic                  r_unmap;
    logic                  w_is_ram;
    logic                  w_is_tx;
    logic                  w_is_st;
    logic                  w_is_cyc;
    logic                  w_unmap_hit;
    logic                  w_st_wr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;
    logic [7:0]            w_count;
    logic [DATA_WIDTH-1:0] w_status;
    // full-width decode so high addresses never alias into RAM
    assign w_is_ram    = data_mem_addr_i < ADDR_WIDTH'(DMEM_DEPTH);
    assign w_is_tx     = data_mem_addr_i == MMIO_BASE + ADDR_WIDTH'(MMIO_TXDATA);
    assign w_is_st     = data_mem_addr_i == MMIO_BASE + ADDR_WIDTH'(MMIO_STATUS);
    assign w_is_cyc    = data_mem_addr_i == MMIO_BASE + ADDR_WIDTH'(MMIO_CYCLE);
    assign w_unmap_hit = (data_mem_read_i | data_mem_write_i) & ~(w_is_ram | w_is_tx | w_is_st | w_is_cyc);
    assign w_st_wr     = data_mem_write_i & w_is_st;
    mmio_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TX_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (data_mem_write_i & w_is_tx),
        .i_data  (data_mem_write_data_i),
        .i_ready (tx_ready_i),
        .o_data  (tx_data_o),
        .o_valid (tx_valid_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );
    // STATUS word assembled from FIFO state and sticky flags
    always_comb begin
        w_status               = '0;
        w_status[7:0]          = w_count;
        w_status[STATUS_FULL]  = w_full;
        w_status[STATUS_EMPTY] = w_empty;
        w_status[STATUS_OVF]   = r_ovf;
        w_status[STATUS_UNMAP] = r_unmap;
    end
    // zero-wait-state read mux; RAM returns the pre-edge word on a same-cycle store
    always_comb begin
        data_mem_read_data_o = ~data_mem_read_i ? '0 :
                               w_is_ram ? r_ram[data_mem_addr_i[RAW-1:0]] :
                               w_is_st  ? w_status :
                               w_is_cyc ? r_cycle : '0;
    end
    // data RAM; contents survive reset
    always_ff @(posedge clk_i) begin
        if (data_mem_write_i & w_is_ram) r_ram[data_mem_addr_i[RAW-1:0]] <= data_mem_write_data_i;
    end
    // free-running cycle counter, loadable by a CYCLE store
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_cycle <= '0;
        else       r_cycle <= (data_mem_write_i & w_is_cyc) ? data_mem_write_data_i : r_cycle + DATA_WIDTH'(1);
    end
    // sticky flags: a setting event beats a same-cycle STATUS clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf   <= 1'b0;
            r_unmap <= 1'b0;
        end else begin
            r_ovf   <= w_drop | (r_ovf & ~(w_st_wr & data_mem_write_data_i[STATUS_OVF]));
            r_unmap <= w_unmap_hit | (r_unmap & ~(w_st_wr & data_mem_write_data_i[STATUS_UNMAP]));
        end
    end
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed and random stimulus checked against a queue/array reference model
module tb_data_mem_bridge;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] TXA  = BASE;
    localparam logic [31:0] STA  = BASE + 32'd1;
    localparam logic [31:0] CYA  = BASE + 32'd2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [31:0] m_q [$];
    logic [31:0] m_cyc;
    bit          m_ovf;
    bit          m_unm;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    data_mem_bridge dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .data_mem_addr_i       (addr),
        .data_mem_read_i       (rd),
        .data_mem_write_i      (wr),
        .data_mem_write_data_i (wdata),
        .data_mem_read_data_o  (rdata),
        .tx_data_o             (tx_data),
        .tx_valid_o            (tx_valid),
        .tx_ready_i            (tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return a < 32'd1024 || a == TXA || a == STA || a == CYA;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_q.size());
        s[8] = m_q.size() == 4;
        s[9] = m_q.size() == 0;
        s[10] = m_ovf;
        s[11] = m_unm;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'd1024) return m_ram[a[9:0]];
        if (a == STA) return model_status();
        if (a == CYA) return m_cyc;
        return '0;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_cyc = '0;
        m_ovf = 1'b0;
        m_unm = 1'b0;
    endfunction

    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        int  sz;
        bit  pop;
        bit  push;
        bit  drop;
        bit  stw;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; tx_ready = rdy;
        #1;
        last_rd = rdata;
        if (!r) chk("rdata_idle", rdata, '0);
        else if (!(a < 32'd1024 && !m_known[a[9:0]])) chk("rdata", rdata, model_read(a));
        chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        chk("tx_data", tx_data, m_q.size() != 0 ? m_q[0] : 32'h0);
        @(posedge clk);
        sz   = m_q.size();
        pop  = sz != 0 && rdy;
        push = w && a == TXA;
        drop = push && sz == 4 && !pop;
        stw  = w && a == STA;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(d);
        m_ovf = drop || (m_ovf && !(stw && d[10]));
        m_unm = ((r || w) && !mapped(a)) || (m_unm && !(stw && d[11]));
        m_cyc = (w && a == CYA) ? d : m_cyc + 32'd1;
        if (w && a < 32'd1024) begin
            m_ram[a[9:0]] = d;
            m_known[a[9:0]] = 1'b1;
        end
    endtask

    task automatic async_reset();
        #3;
        rd = 0; wr = 0; tx_ready = 0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_txdata", tx_data, 32'h0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        model_clear();
        #1;
        chk("por_valid", 32'(tx_valid), 32'h0);
        chk("por_txdata", tx_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, STA, 0, 0);
        chk("reset_status", last_rd, 32'h200);
        step(1, 0, CYA, 0, 0);
        chk("reset_cycle", last_rd, 32'h1);
        // RAM store then load, and same-cycle read-during-write
        step(0, 1, 5, 32'hDEADBEEF, 0);
        step(1, 0, 5, 0, 0);
        chk("ram_load", last_rd, 32'hDEADBEEF);
        step(1, 1, 5, 32'h1, 0);
        chk("ram_rdw_old", last_rd, 32'hDEADBEEF);
        step(1, 0, 5, 0, 0);
        chk("ram_new", last_rd, 32'h1);
        // fill FIFO, overflow, drain
        foreach (m_ram[i]) if (i < 0) m_ram[i] = '0;
        step(0, 1, TXA, 32'h11, 0);
        step(0, 1, TXA, 32'h22, 0);
        step(0, 1, TXA, 32'h33, 0);
        step(1, 1, TXA, 32'h44, 0);
        chk("txdata_read", last_rd, 32'h0);
        step(1, 0, STA, 0, 0);
        chk("status_full", last_rd, 32'h104);
        step(0, 1, TXA, 32'h55, 0);
        step(1, 0, STA, 0, 0);
        chk("status_ovf", last_rd, 32'h504);
        step(0, 1, STA, 32'h400, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(1, 0, STA, 0, 0);
        chk("status_empty", last_rd, 32'h200);
        // push into full FIFO while popping
        for (int i = 0; i < 4; i++) step(0, 1, TXA, 32'hA0 + 32'(i), 0);
        step(0, 1, TXA, 32'h99, 1);
        step(1, 0, STA, 0, 0);
        chk("full_pushpop", last_rd, 32'h104);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        // counter wrap
        step(0, 1, CYA, 32'hFFFF_FFFE, 0);
        step(1, 0, CYA, 0, 0);
        chk("cyc0", last_rd, 32'hFFFF_FFFE);
        step(1, 0, CYA, 0, 0);
        chk("cyc1", last_rd, 32'hFFFF_FFFF);
        step(1, 0, CYA, 0, 0);
        chk("cyc2", last_rd, 32'h0);
        // unmapped access and clear
        step(1, 0, 32'h8000_0000, 0, 0);
        chk("unmap_read", last_rd, 32'h0);
        step(1, 0, STA, 0, 0);
        chk("unmap_flag", last_rd, 32'hA00);
        step(0, 1, STA, 32'h800, 0);
        step(1, 0, STA, 0, 0);
        chk("unmap_clear", last_rd, 32'h200);
        step(0, 1, 32'd1024, 32'h1234, 0);
        step(1, 0, STA, 0, 0);
        chk("unmap_boundary", last_rd, 32'hA00);
        // async reset with pending entries; RAM survives
        step(0, 1, 5, 32'hDEADBEEF, 0);
        for (int i = 0; i < 3; i++) step(0, 1, TXA, 32'h70 + 32'(i), 0);
        async_reset();
        step(1, 0, STA, 0, 0);
        chk("post_rst_status", last_rd, 32'h200);
        step(1, 0, 5, 0, 0);
        chk("post_rst_ram", last_rd, 32'hDEADBEEF);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            k = int'($urandom_range(0, 9));
            d = $urandom;
            case (k)
                0, 1, 2: a = $urandom_range(0, 15);
                3, 4:    a = TXA;
                5:       a = STA;
                6:       a = ($urandom_range(0, 3) == 0) ? CYA : STA;
                7:       a = 32'd1023;
                default: begin
                    k = int'($urandom_range(0, 4));
                    a = k == 0 ? 32'd1024 : k == 1 ? BASE - 32'd1 : k == 2 ? BASE + 32'd3 :
                        k == 3 ? 32'h8000_0000 : 32'h1000 + ($urandom & 32'h0FFF_FFFF);
                end
            endcase
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 2) == 0));
        end
        @(negedge clk);
        rd = 0; wr = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
